vram_arb: RTL and testbench

- Parametrised successor to the PPU's single-port VRAM.
- One shared single-port array serves two requesters: the CPU (read/write, with ready/valid handshake) and the PPU fetcher (read-only, fixed priority).
- Adds CPU stall buffering, PPU-mode lockout (CPU reads return all-ones, CPU writes dropped) and registered read data with valid strobes.
- Sits between the CPU bus decoder and the PPU tile/sprite fetch logic.

---
 rtl/vram_arb.sv | 163 ++++++++++++++++
 tb/tb_vram_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// Shared single-port VRAM arbiter: PPU fetcher (fixed priority) and CPU (ready/valid, one-entry stall buffer).
// Optional power-up zero fill of the array is built in when VRAM_CLEAR_EN is defined.
`timescale 1ns/1ps
module vram_arb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ppu_lock,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_rdata,
  output logic              ppu_rvalid
);

  localparam int DEPTH = 2**ADDR_W;

  logic              run;
  logic [ADDR_W-1:0] clr_addr;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    if (state_reg == ST_CLEAR) begin
      clr_addr_next = clr_addr_reg + 1'b1;
      if (clr_addr_reg == {ADDR_W{1'b1}}) state_next = ST_RUN;
    end
  end

  assign run      = (state_reg == ST_RUN);
  assign clr_addr = clr_addr_reg;
`else
  assign run      = 1'b1;
  assign clr_addr = '0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  logic              pend_valid_reg;
  logic              pend_we_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [DATA_W-1:0] pend_wdata_reg;

  logic              cpu_rvalid_reg, cpu_ones_reg, ppu_rvalid_reg;
  logic [DATA_W-1:0] cpu_hold_reg, ppu_hold_reg;

  logic              accept;
  logic              svc_we;
  logic [ADDR_W-1:0] svc_addr;
  logic [DATA_W-1:0] svc_wdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ppu_rd, cpu_rd, cpu_lock_rd;
  logic              pend_load, pend_clear;

  assign cpu_ready = run && !pend_valid_reg;
  assign accept    = cpu_req && cpu_ready;

  // A pending request always outranks a new one; while pending, cpu_ready is low anyway.
  assign svc_we    = pend_valid_reg ? pend_we_reg    : cpu_we;
  assign svc_addr  = pend_valid_reg ? pend_addr_reg  : cpu_addr;
  assign svc_wdata = pend_valid_reg ? pend_wdata_reg : cpu_wdata;

  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = ppu_addr;
    mem_wdata   = '0;
    ppu_rd      = 1'b0;
    cpu_rd      = 1'b0;
    cpu_lock_rd = 1'b0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;
    if (!run) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (ppu_req) begin
      mem_re    = 1'b1;
      mem_addr  = ppu_addr;
      ppu_rd    = 1'b1;
      pend_load = accept;
    end else if (pend_valid_reg || accept) begin
      pend_clear = pend_valid_reg;
      mem_addr   = svc_addr;
      if (ppu_lock) begin
        // Locked out: reads answer all-ones without touching the array, writes vanish.
        cpu_lock_rd = !svc_we;
      end else if (svc_we) begin
        mem_we    = 1'b1;
        mem_wdata = svc_wdata;
      end else begin
        mem_re = 1'b1;
        cpu_rd = 1'b1;
      end
    end
  end

  // Array port kept free of reset so it maps onto block RAM; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[mem_addr] <= mem_wdata;
    if (mem_re) rd_data_reg <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_we_reg    <= 1'b0;
      pend_addr_reg  <= '0;
      pend_wdata_reg <= '0;
      cpu_rvalid_reg <= 1'b0;
      cpu_ones_reg   <= 1'b0;
      ppu_rvalid_reg <= 1'b0;
      cpu_hold_reg   <= '0;
      ppu_hold_reg   <= '0;
    end else begin
      if (pend_load) begin
        pend_valid_reg <= 1'b1;
        pend_we_reg    <= cpu_we;
        pend_addr_reg  <= cpu_addr;
        pend_wdata_reg <= cpu_wdata;
      end else if (pend_clear) begin
        pend_valid_reg <= 1'b0;
      end
      cpu_rvalid_reg <= cpu_rd || cpu_lock_rd;
      cpu_ones_reg   <= cpu_lock_rd;
      ppu_rvalid_reg <= ppu_rd;
      if (cpu_rvalid_reg) cpu_hold_reg <= cpu_rdata;
      if (ppu_rvalid_reg) ppu_hold_reg <= ppu_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_reg;
  assign ppu_rvalid = ppu_rvalid_reg;
  assign cpu_rdata  = cpu_rvalid_reg ? (cpu_ones_reg ? {DATA_W{1'b1}} : rd_data_reg) : cpu_hold_reg;
  assign ppu_rdata  = ppu_rvalid_reg ? rd_data_reg : ppu_hold_reg;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb: CPU path, PPU collision, starvation, lockout, reset mid-op, optional clear.
`timescale 1ns/1ps
module tb_vram_arb;

`ifdef VRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ppu_lock, ppu_req, ppu_rvalid;
  logic [12:0] ppu_addr;
  logic [7:0]  ppu_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  vram_arb #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ppu_lock(ppu_lock), .ppu_req(ppu_req), .ppu_addr(ppu_addr),
    .ppu_rdata(ppu_rdata), .ppu_rvalid(ppu_rvalid)
  );

`ifdef VRAM_CLEAR_EN
  logic       c_rst_n, c_cpu_req, c_cpu_we, c_cpu_ready, c_cpu_rvalid;
  logic       c_ppu_req, c_ppu_rvalid;
  logic [3:0] c_cpu_addr, c_ppu_addr;
  logic [7:0] c_cpu_wdata, c_cpu_rdata, c_ppu_rdata;

  vram_arb #(.ADDR_W(4), .DATA_W(8)) dut_clr (
    .clk(clk), .rst_n(c_rst_n),
    .cpu_req(c_cpu_req), .cpu_ready(c_cpu_ready), .cpu_we(c_cpu_we),
    .cpu_addr(c_cpu_addr), .cpu_wdata(c_cpu_wdata), .cpu_rdata(c_cpu_rdata), .cpu_rvalid(c_cpu_rvalid),
    .ppu_lock(1'b0), .ppu_req(c_ppu_req), .ppu_addr(c_ppu_addr),
    .ppu_rdata(c_ppu_rdata), .ppu_rvalid(c_ppu_rvalid)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 10000) begin
      tick();
      n++;
    end
    check("ready_after_reset", {31'd0, cpu_ready}, 32'd1);
  endtask

  task automatic cpu_read_check(input string tag, input logic [12:0] a, input logic [7:0] exp);
    cpu_op(1'b0, a, 8'h00);
    check({tag, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd1);
    check({tag, "_rdata"}, {24'd0, cpu_rdata}, {24'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ppu_lock = 1'b0; ppu_req = 1'b0; ppu_addr = '0;
    repeat (3) tick();

    // Reset state
    check("rst_cpu_ready", {31'd0, cpu_ready}, {31'd0, !CLR});
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_ppu_rvalid", {31'd0, ppu_rvalid}, 32'd0);
    check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rst_ppu_rdata", {24'd0, ppu_rdata}, 32'd0);
    rst_n = 1'b1;
    wait_ready();

    // Basic CPU path
    cpu_op(1'b1, 13'h004, 8'h02);
    check("wr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cpu_read_check("rd004", 13'h004, 8'h02);
    tick();
    check("rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);
    check("rdata_hold", {24'd0, cpu_rdata}, 32'h02);
    cpu_op(1'b1, 13'h005, 8'h03);
    cpu_read_check("rd005", 13'h005, 8'h03);
    cpu_read_check("rd004b", 13'h004, 8'h02);

    // Preload
    cpu_op(1'b1, 13'h010, 8'h00);
    cpu_op(1'b1, 13'h020, 8'h5A);
    cpu_op(1'b1, 13'h030, 8'h11);
    cpu_op(1'b1, 13'h040, 8'h33);

    // Collision: PPU wins, CPU write buffered
    ppu_req = 1'b1; ppu_addr = 13'h010;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h010; cpu_wdata = 8'hA5;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; ppu_req = 1'b0;
    check("col_ppu_rvalid", {31'd0, ppu_rvalid}, 32'd1);
    check("col_ppu_rdata", {24'd0, ppu_rdata}, 32'h00);
    check("col_ready_low", {31'd0, cpu_ready}, 32'd0);
    tick();
    check("col_ready_back", {31'd0, cpu_ready}, 32'd1);
    check("col_ppu_rvalid_drop", {31'd0, ppu_rvalid}, 32'd0);
    ppu_req = 1'b1; ppu_addr = 13'h010;
    tick();
    ppu_req = 1'b0;
    check("col_ppu_new_rvalid", {31'd0, ppu_rvalid}, 32'd1);
    check("col_ppu_new_rdata", {24'd0, ppu_rdata}, 32'hA5);

    // Starvation and recovery
    ppu_req = 1'b1; ppu_addr = 13'h004;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h020;
    tick();
    cpu_req = 1'b0;
    check("stv_ready_0", {31'd0, cpu_ready}, 32'd0);
    check("stv_ppu_rdata", {24'd0, ppu_rdata}, 32'h02);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("stv_ready_%0d", i), {31'd0, cpu_ready}, 32'd0);
      check($sformatf("stv_rvalid_%0d", i), {31'd0, cpu_rvalid}, 32'd0);
    end
    ppu_req = 1'b0;
    tick();
    check("stv_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("stv_rdata", {24'd0, cpu_rdata}, 32'h5A);
    check("stv_ready_back", {31'd0, cpu_ready}, 32'd1);

    // Lockout
    ppu_lock = 1'b1;
    cpu_op(1'b1, 13'h030, 8'h77);
    check("lk_wr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cpu_read_check("lk_rd", 13'h030, 8'hFF);
    ppu_lock = 1'b0;
    cpu_read_check("unlk_rd", 13'h030, 8'h11);

    // Reset drops rvalid asynchronously
    cpu_read_check("pre_rst_rd", 13'h005, 8'h03);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_ready();

    // Reset with a pending write: the write is discarded
    ppu_req = 1'b1; ppu_addr = 13'h000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h040; cpu_wdata = 8'h44;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; ppu_req = 1'b0;
    check("pend_ready_low", {31'd0, cpu_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("pend_rst_ready", {31'd0, cpu_ready}, {31'd0, !CLR});
    check("pend_rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_ready();
`ifndef VRAM_CLEAR_EN
    cpu_read_check("pend_discarded", 13'h040, 8'h33);
`else
    cpu_read_check("pend_discarded", 13'h040, 8'h00);
`endif

`ifdef VRAM_CLEAR_EN
    // Zero fill on a 16-entry array
    c_rst_n = 1'b0; c_cpu_req = 1'b0; c_cpu_we = 1'b0; c_cpu_addr = '0; c_cpu_wdata = '0;
    c_ppu_req = 1'b1; c_ppu_addr = '0;
    tick();
    c_rst_n = 1'b1;
    check("clr_ready_0", {31'd0, c_cpu_ready}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("clr_ready_%0d", i), {31'd0, c_cpu_ready}, 32'd0);
      check($sformatf("clr_ppu_rvalid_%0d", i), {31'd0, c_ppu_rvalid}, 32'd0);
    end
    c_ppu_req = 1'b0;
    tick();
    check("clr_ready_done", {31'd0, c_cpu_ready}, 32'd1);
    for (int a = 0; a < 16; a++) begin
      c_cpu_req = 1'b1; c_cpu_addr = a[3:0];
      tick();
      c_cpu_req = 1'b0;
      check($sformatf("clr_rv_%0d", a), {31'd0, c_cpu_rvalid}, 32'd1);
      check($sformatf("clr_rd_%0d", a), {24'd0, c_cpu_rdata}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
